mc_controller: RTL and testbench

- Multicycle successor to the single-cycle MIPS controller: one FSM sequences fetch/decode/execute/memory/writeback over several cycles and drives datapath mux selects, enables and ALU control.
- Adds memory wait-state handshake, BNE, ANDI/ORI/SLTI with zero/sign-extend select, illegal-opcode flag and a parametrised ALU control width.
- Sits beside the multicycle datapath and a shared instruction/data memory.

---
 rtl/mc_controller.sv | 208 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM.
// Sequences fetch/decode/execute/memory/writeback. Drives the datapath mux
// selects, the enables and the ALU control. It waits on mem_ready for memory
// accesses.
// Optional build macro: MC_CTRL_INSTRET_EN adds the instret retired-instruction
// counter port.
module mc_controller #(
  parameter int unsigned ALUCTRL_W = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 pcen,
  output logic [1:0]           pcsrc,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 zeroext,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal
`ifdef MC_CTRL_INSTRET_EN
  ,
  output logic [CNT_W-1:0]     instret
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP
  } state_t;

  state_t     state, next;
  logic [3:0] alu4;
  logic       memwrite_c, irwrite_c, pcen_c, regwrite_c;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next;
  end

  // Next-state and Moore output decode.
  always_comb begin
    next       = state;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    pcen_c     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_c = 1'b0;
    alu4       = ALU_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite_c = 1'b1;
          pcen_c    = 1'b1;
          next      = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:                     next = S_MEMADR;
          OP_RTYPE:                         next = S_RTYPEEX;
          OP_BEQ, OP_BNE:                   next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next = S_IMMEX;
          OP_J:                             next = S_JUMP;
          default: begin
            illegal = 1'b1;
            next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 1'b1;
        next       = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          memwrite_c = 1'b1;
          next       = S_FETCH;
        end
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        next    = S_ALUWB;
        case (funct)
          6'b100000: alu4 = ALU_ADD;
          6'b100010: alu4 = ALU_SUB;
          6'b100100: alu4 = ALU_AND;
          6'b100101: alu4 = ALU_OR;
          6'b101010: alu4 = ALU_SLT;
          6'b100110: alu4 = ALU_XOR;
          6'b100111: alu4 = ALU_NOR;
          default: begin
            illegal = 1'b1;
            next    = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst     = 1'b1;
        next       = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        alu4    = ALU_SUB;
        pcsrc   = 2'b01;
        pcen_c  = (op == OP_BNE) ? ~zero : zero;
        next    = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        next    = S_IMMWB;
        case (op)
          OP_ANDI: begin zeroext = 1'b1; alu4 = ALU_AND; end
          OP_ORI:  begin zeroext = 1'b1; alu4 = ALU_OR;  end
          OP_SLTI: alu4 = ALU_SLT;
          default: alu4 = ALU_ADD;
        endcase
      end
      S_IMMWB: begin
        regwrite_c = 1'b1;
        next       = S_FETCH;
      end
      S_JUMP: begin
        pcsrc  = 2'b10;
        pcen_c = 1'b1;
        next   = S_FETCH;
      end
      default: next = S_FETCH;
    endcase
  end

  // Write strobes are held low while reset is asserted so nothing glitches.
  assign memwrite   = memwrite_c & reset;
  assign irwrite    = irwrite_c  & reset;
  assign pcen       = pcen_c     & reset;
  assign regwrite   = regwrite_c & reset;
  assign alucontrol = ALUCTRL_W'(alu4);

`ifdef MC_CTRL_INSTRET_EN
  logic retire;
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_IMMWB) ||
                  (state == S_BRANCH) || (state == S_JUMP) ||
                  ((state == S_MEMWR) && mem_ready);

  // Retired-instruction counter; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller.
// Each stimulus cycle queues the hand-derived control word that is expected.
// A negedge monitor pops each word and compares it with the DUT outputs.
module tb_mc_controller;
  localparam int unsigned AW = 6;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, iord, memwrite, irwrite, pcen, alusrca, zeroext, regdst, memtoreg, regwrite, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [AW-1:0] alucontrol;
`ifdef MC_CTRL_INSTRET_EN
  logic [CW-1:0] instret;
`endif

  mc_controller #(.ALUCTRL_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alucontrol(alucontrol), .illegal(illegal)
`ifdef MC_CTRL_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mreq, iord, mw, irw, pcen;
    logic [1:0] pcsrc;
    logic asa;
    logic [1:0] asb;
    logic zx, rd, m2r, rw;
    logic [AW-1:0] alu;
    logic ill;
  } cw_t;

  cw_t   expq[$];
  string nameq[$];
  int    checks = 0;
  int    fails  = 0;

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_ = 4'b0000, OR_ = 4'b0001,
                         SLT = 4'b0111, XOR_ = 4'b0011;

  function automatic cw_t cw(logic mreq, logic io, logic mw, logic irw, logic pc,
                             logic [1:0] pcs, logic asa, logic [1:0] asb,
                             logic zx, logic rd, logic m2r, logic rw,
                             logic [3:0] alu, logic ill);
    cw_t c;
    c.mreq = mreq; c.iord = io; c.mw = mw; c.irw = irw; c.pcen = pc;
    c.pcsrc = pcs; c.asa = asa; c.asb = asb; c.zx = zx; c.rd = rd;
    c.m2r = m2r; c.rw = rw; c.alu = AW'(alu); c.ill = ill;
    return c;
  endfunction

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    cw_t a, e;
    string n;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n = nameq.pop_front();
      a.mreq = mem_req; a.iord = iord; a.mw = memwrite; a.irw = irwrite; a.pcen = pcen;
      a.pcsrc = pcsrc; a.asa = alusrca; a.asb = alusrcb; a.zx = zeroext; a.rd = regdst;
      a.m2r = memtoreg; a.rw = regwrite; a.alu = alucontrol; a.ill = illegal;
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got %b expected %b", n, a, e);
      end
    end
  end

  task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic r, input cw_t e, input string n);
    @(posedge clk);
    #1;
    reset = rst; op = o; funct = f; zero = z; mem_ready = r;
    expq.push_back(e);
    nameq.push_back(n);
  endtask

  task automatic chk_instret(input int exp_v, input string n);
`ifdef MC_CTRL_INSTRET_EN
    @(negedge clk);
    #1;
    checks++;
    if (instret !== CW'(exp_v)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, instret, exp_v);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    cw_t fetch_r, fetch_w, decode, dec_ill, memadr, memrd, memwb, memwr_r;
    cw_t aluwb, rt_ill, immwb, jump;
    fetch_r = cw(1,0,0,1,1,2'b00,0,2'b01,0,0,0,0,ADD,0);
    fetch_w = cw(1,0,0,0,0,2'b00,0,2'b01,0,0,0,0,ADD,0);
    decode  = cw(0,0,0,0,0,2'b00,0,2'b11,0,0,0,0,ADD,0);
    dec_ill = cw(0,0,0,0,0,2'b00,0,2'b11,0,0,0,0,ADD,1);
    memadr  = cw(0,0,0,0,0,2'b00,1,2'b10,0,0,0,0,ADD,0);
    memrd   = cw(1,1,0,0,0,2'b00,0,2'b00,0,0,0,0,ADD,0);
    memwb   = cw(0,0,0,0,0,2'b00,0,2'b00,0,0,1,1,ADD,0);
    memwr_r = cw(1,1,1,0,0,2'b00,0,2'b00,0,0,0,0,ADD,0);
    aluwb   = cw(0,0,0,0,0,2'b00,0,2'b00,0,1,0,1,ADD,0);
    rt_ill  = cw(0,0,0,0,0,2'b00,1,2'b00,0,0,0,0,ADD,1);
    immwb   = cw(0,0,0,0,0,2'b00,0,2'b00,0,0,0,1,ADD,0);
    jump    = cw(0,0,0,0,1,2'b10,0,2'b00,0,0,0,0,ADD,0);

    // Reset held: FETCH decode with strobes suppressed even though mem_ready=1.
    step(0, 6'b100011, 6'd0, 0, 1, fetch_w, "reset_fetch");
    chk_instret(0, "instret_after_reset");
    // lw, no waits: 5 cycles.
    step(1, 6'b100011, 6'd0, 0, 1, fetch_r, "lw_fetch");
    step(1, 6'b100011, 6'd0, 0, 1, decode,  "lw_decode");
    step(1, 6'b100011, 6'd0, 0, 1, memadr,  "lw_memadr");
    step(1, 6'b100011, 6'd0, 0, 1, memrd,   "lw_memrd");
    step(1, 6'b100011, 6'd0, 0, 1, memwb,   "lw_memwb");
    // sw with a 2-cycle stall in MEMWR: 6 cycles, one memwrite pulse.
    step(1, 6'b101011, 6'd0, 0, 1, fetch_r, "sw_fetch");
    step(1, 6'b101011, 6'd0, 0, 1, decode,  "sw_decode");
    step(1, 6'b101011, 6'd0, 0, 1, memadr,  "sw_memadr");
    step(1, 6'b101011, 6'd0, 0, 0, memrd,   "sw_stall1");
    step(1, 6'b101011, 6'd0, 0, 0, memrd,   "sw_stall2");
    step(1, 6'b101011, 6'd0, 0, 1, memwr_r, "sw_write");
    // beq taken, bne not taken, both with zero=1.
    step(1, 6'b000100, 6'd0, 1, 1, fetch_r, "beq_fetch");
    step(1, 6'b000100, 6'd0, 1, 1, decode,  "beq_decode");
    step(1, 6'b000100, 6'd0, 1, 1, cw(0,0,0,0,1,2'b01,1,2'b00,0,0,0,0,SUB,0), "beq_branch");
    step(1, 6'b000101, 6'd0, 1, 1, fetch_r, "bne_fetch");
    step(1, 6'b000101, 6'd0, 1, 1, decode,  "bne_decode");
    step(1, 6'b000101, 6'd0, 1, 1, cw(0,0,0,0,0,2'b01,1,2'b00,0,0,0,0,SUB,0), "bne_branch");
    // R-type xor, then an unsupported funct.
    step(1, 6'b000000, 6'b100110, 0, 1, fetch_r, "xor_fetch");
    step(1, 6'b000000, 6'b100110, 0, 1, decode,  "xor_decode");
    step(1, 6'b000000, 6'b100110, 0, 1, cw(0,0,0,0,0,2'b00,1,2'b00,0,0,0,0,XOR_,0), "xor_ex");
    step(1, 6'b000000, 6'b100110, 0, 1, aluwb,   "xor_wb");
    step(1, 6'b000000, 6'b000001, 0, 1, fetch_r, "badfn_fetch");
    step(1, 6'b000000, 6'b000001, 0, 1, decode,  "badfn_decode");
    step(1, 6'b000000, 6'b000001, 0, 1, rt_ill,  "badfn_ex");
    // Back in FETCH directly after the illegal funct; also a fetch wait.
    step(1, 6'b001101, 6'd0, 0, 0, fetch_w, "ori_fetch_wait");
    step(1, 6'b001101, 6'd0, 0, 1, fetch_r, "ori_fetch");
    step(1, 6'b001101, 6'd0, 0, 1, decode,  "ori_decode");
    step(1, 6'b001101, 6'd0, 0, 1, cw(0,0,0,0,0,2'b00,1,2'b10,1,0,0,0,OR_,0), "ori_ex");
    step(1, 6'b001101, 6'd0, 0, 1, immwb,   "ori_wb");
    step(1, 6'b001010, 6'd0, 0, 1, fetch_r, "slti_fetch");
    step(1, 6'b001010, 6'd0, 0, 1, decode,  "slti_decode");
    step(1, 6'b001010, 6'd0, 0, 1, cw(0,0,0,0,0,2'b00,1,2'b10,0,0,0,0,SLT,0), "slti_ex");
    step(1, 6'b001010, 6'd0, 0, 1, immwb,   "slti_wb");
    step(1, 6'b001100, 6'd0, 0, 1, fetch_r, "andi_fetch");
    step(1, 6'b001100, 6'd0, 0, 1, decode,  "andi_decode");
    step(1, 6'b001100, 6'd0, 0, 1, cw(0,0,0,0,0,2'b00,1,2'b10,1,0,0,0,AND_,0), "andi_ex");
    step(1, 6'b001100, 6'd0, 0, 1, immwb,   "andi_wb");
    step(1, 6'b000010, 6'd0, 0, 1, fetch_r, "j_fetch");
    step(1, 6'b000010, 6'd0, 0, 1, decode,  "j_decode");
    step(1, 6'b000010, 6'd0, 0, 1, jump,    "j_jump");
    // Unsupported opcode: illegal in DECODE, then FETCH.
    step(1, 6'b111111, 6'd0, 0, 1, fetch_r, "badop_fetch");
    step(1, 6'b111111, 6'd0, 0, 1, dec_ill, "badop_decode");
    step(1, 6'b100011, 6'd0, 0, 1, fetch_r, "lw2_fetch");
    chk_instret(9, "instret_before_abort");
    step(1, 6'b100011, 6'd0, 0, 1, decode,  "lw2_decode");
    step(1, 6'b100011, 6'd0, 0, 1, memadr,  "lw2_memadr");
    step(1, 6'b100011, 6'd0, 0, 0, memrd,   "lw2_memrd_wait");
    // Reset asserted while in MEMRD: FETCH at once, strobes suppressed.
    step(0, 6'b100011, 6'd0, 0, 1, fetch_w, "abort_reset");
    chk_instret(0, "instret_abort_reset");
    step(1, 6'b000100, 6'd0, 0, 1, fetch_r, "beq0_fetch");
    step(1, 6'b000100, 6'd0, 0, 1, decode,  "beq0_decode");
    step(1, 6'b000100, 6'd0, 0, 1, cw(0,0,0,0,0,2'b01,1,2'b00,0,0,0,0,SUB,0), "beq0_branch");
    step(1, 6'b000010, 6'd0, 0, 1, fetch_r, "j2_fetch");
    step(1, 6'b000010, 6'd0, 0, 1, decode,  "j2_decode");
    step(1, 6'b000010, 6'd0, 0, 1, jump,    "j2_jump");
    step(1, 6'b001000, 6'd0, 0, 1, fetch_r, "addi_fetch");
    step(1, 6'b001000, 6'd0, 0, 1, decode,  "addi_decode");
    step(1, 6'b001000, 6'd0, 0, 1, cw(0,0,0,0,0,2'b00,1,2'b10,0,0,0,0,ADD,0), "addi_ex");
    step(1, 6'b001000, 6'd0, 0, 1, immwb,   "addi_wb");
    step(1, 6'b001000, 6'd0, 0, 0, fetch_w, "final_fetch");
    chk_instret(3, "instret_three");

    repeat (2) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
